// File: rtl/ysyx_24080006_axi_arbiter_if.sv
// AXI4 bundle shared by the IFU, LSU and crossbar-side ports of the memory arbiter.
interface ysyx_24080006_axi #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/ysyx_24080006_axi_arbiter.sv
// IFU/LSU to single AXI4 port arbiter, one outstanding transaction, grant held to retirement.
// Define YSYX_24080006_ARB_RR_EN for round-robin between the two readers (LSU writes still win).
module ysyx_24080006_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    ysyx_24080006_axi.slave  ifu,
    ysyx_24080006_axi.slave  lsu,
    ysyx_24080006_axi.master out
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RD_IFU = 2'd1;
    localparam logic [1:0] S_RD_LSU = 2'd2;
    localparam logic [1:0] S_WR_LSU = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_addr_done;
    logic              w_addr_done_nxt;
    logic              w_g_ifu;
    logic              w_g_lsu_rd;
    logic              w_g_lsu_wr;
    logic              w_ar_hs;
    logic              w_aw_hs;
    logic              w_r_done;
    logic              w_b_done;
    logic              w_pick_lsu;
    logic [ADDR_W-1:0] w_araddr;
    logic [ID_W-1:0]   w_arid;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    // Grants are masked by reset so every handshake signal is quiet while reset is held.
    assign w_g_ifu    = !reset && (r_state == S_RD_IFU);
    assign w_g_lsu_rd = !reset && (r_state == S_RD_LSU);
    assign w_g_lsu_wr = !reset && (r_state == S_WR_LSU);

    assign w_ar_hs  = out.arvalid && out.arready;
    assign w_aw_hs  = out.awvalid && out.awready;
    assign w_r_done = out.rvalid && out.rready && out.rlast;
    assign w_b_done = out.bvalid && out.bready;

`ifdef YSYX_24080006_ARB_RR_EN
    logic r_last_rd;
    // r_last_rd = 1 means LSU was the most recent reader; on a tie the other reader wins.
    assign w_pick_lsu = lsu.arvalid && (!ifu.arvalid || !r_last_rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_rd <= 1'b0;
        end else if (r_state == S_IDLE && w_state_nxt == S_RD_LSU) begin
            r_last_rd <= 1'b1;
        end else if (r_state == S_IDLE && w_state_nxt == S_RD_IFU) begin
            r_last_rd <= 1'b0;
        end
    end
`else
    assign w_pick_lsu = lsu.arvalid;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_done_nxt = r_addr_done;
        case (r_state)
            S_IDLE: begin
                w_addr_done_nxt = 1'b0;
                if (lsu.awvalid)      w_state_nxt = S_WR_LSU;
                else if (w_pick_lsu)  w_state_nxt = S_RD_LSU;
                else if (ifu.arvalid) w_state_nxt = S_RD_IFU;
            end
            S_RD_IFU, S_RD_LSU: begin
                if (w_r_done) begin
                    w_state_nxt     = S_IDLE;
                    w_addr_done_nxt = 1'b0;
                end else if (w_ar_hs) begin
                    w_addr_done_nxt = 1'b1;
                end
            end
            S_WR_LSU: begin
                if (w_b_done) begin
                    w_state_nxt     = S_IDLE;
                    w_addr_done_nxt = 1'b0;
                end else if (w_aw_hs) begin
                    w_addr_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_addr_done_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_done <= w_addr_done_nxt;
        end
    end

    assign w_araddr    = w_g_lsu_rd ? lsu.araddr : ifu.araddr;
    assign w_arid      = w_g_lsu_rd ? lsu.arid   : ifu.arid;
    assign out.araddr  = w_araddr;
    assign out.arid    = w_arid;
    assign out.arlen   = w_g_lsu_rd ? lsu.arlen   : ifu.arlen;
    assign out.arsize  = w_g_lsu_rd ? lsu.arsize  : ifu.arsize;
    assign out.arburst = w_g_lsu_rd ? lsu.arburst : ifu.arburst;
    assign out.arvalid = ((w_g_ifu && ifu.arvalid) || (w_g_lsu_rd && lsu.arvalid)) && !r_addr_done;
    assign ifu.arready = w_g_ifu && !r_addr_done && out.arready;
    assign lsu.arready = w_g_lsu_rd && !r_addr_done && out.arready;

    assign out.rready = (w_g_ifu && ifu.rready) || (w_g_lsu_rd && lsu.rready);
    assign w_rdata    = out.rdata;
    assign ifu.rvalid = w_g_ifu && out.rvalid;
    assign ifu.rdata  = w_rdata;
    assign ifu.rresp  = out.rresp;
    assign ifu.rlast  = out.rlast;
    assign ifu.rid    = out.rid;
    assign lsu.rvalid = w_g_lsu_rd && out.rvalid;
    assign lsu.rdata  = w_rdata;
    assign lsu.rresp  = out.rresp;
    assign lsu.rlast  = out.rlast;
    assign lsu.rid    = out.rid;

    // Only the LSU can write, so the AW/W payload comes straight from it.
    assign out.awaddr  = lsu.awaddr;
    assign out.awid    = lsu.awid;
    assign out.awlen   = lsu.awlen;
    assign out.awsize  = lsu.awsize;
    assign out.awburst = lsu.awburst;
    assign out.awvalid = w_g_lsu_wr && lsu.awvalid && !r_addr_done;
    assign lsu.awready = w_g_lsu_wr && !r_addr_done && out.awready;
    assign out.wdata   = lsu.wdata;
    assign out.wstrb   = lsu.wstrb;
    assign out.wlast   = lsu.wlast;
    assign out.wvalid  = w_g_lsu_wr && lsu.wvalid;
    assign lsu.wready  = w_g_lsu_wr && out.wready;
    assign lsu.bvalid  = w_g_lsu_wr && out.bvalid;
    assign lsu.bresp   = out.bresp;
    assign lsu.bid     = out.bid;
    assign out.bready  = w_g_lsu_wr && lsu.bready;

    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bvalid  = 1'b0;
    assign ifu.bresp   = 2'b00;
    assign ifu.bid     = '0;

    assign w_unused = &{1'b0, ifu.awvalid, ifu.awaddr, ifu.awid, ifu.awlen, ifu.awsize,
                        ifu.awburst, ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.wlast, ifu.bready};
endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Directed vector bench for the IFU/LSU AXI arbiter (default fixed-priority build).
module tb_ysyx_24080006_axi_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24080006_axi #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) ifu_bus ();
    ysyx_24080006_axi #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) lsu_bus ();
    ysyx_24080006_axi #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) out_bus ();

    ysyx_24080006_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clock (clk),
        .reset (rst),
        .ifu   (ifu_bus),
        .lsu   (lsu_bus),
        .out   (out_bus)
    );

    // in[13:0]  = {rst, ifu.arvalid, ifu.rready, lsu.awvalid, lsu.wvalid, lsu.bready,
    //              lsu.arvalid, lsu.rready, out.arready, out.awready, out.wready,
    //              out.rvalid, out.rlast, out.bvalid}
    // exp[11:0] = {out.arvalid, out.awvalid, out.wvalid, out.rready, out.bready,
    //              ifu.arready, ifu.rvalid, lsu.arready, lsu.awready, lsu.wready,
    //              lsu.rvalid, lsu.bvalid}
    typedef struct {
        string       name;
        logic [13:0] in;
        logic [31:0] rdata;
        logic [11:0] exp;
        logic [31:0] araddr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_ar  = 0;
    int   n_aw  = 0;
    int   n_w   = 0;
    int   n_b   = 0;

    function automatic logic [11:0] flags();
        return {out_bus.arvalid, out_bus.awvalid, out_bus.wvalid, out_bus.rready, out_bus.bready,
                ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.awready,
                lsu_bus.wready, lsu_bus.rvalid, lsu_bus.bvalid};
    endfunction

    task automatic add(input string nm, input logic [13:0] in, input logic [31:0] rd,
                       input logic [11:0] exp, input logic [31:0] addr);
        vec_t v;
        v.name = nm; v.in = in; v.rdata = rd; v.exp = exp; v.araddr = addr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [13:0] in, input logic [31:0] rd);
        rst             = in[13];
        ifu_bus.arvalid = in[12];
        ifu_bus.rready  = in[11];
        lsu_bus.awvalid = in[10];
        lsu_bus.wvalid  = in[9];
        lsu_bus.bready  = in[8];
        lsu_bus.arvalid = in[7];
        lsu_bus.rready  = in[6];
        out_bus.arready = in[5];
        out_bus.awready = in[4];
        out_bus.wready  = in[3];
        out_bus.rvalid  = in[2];
        out_bus.rlast   = in[1];
        out_bus.bvalid  = in[0];
        out_bus.rdata   = rd;
    endtask

    // One clock per step: drive after the falling edge, sample 2 ns later.
    task automatic step(input string nm, input logic [13:0] in, input logic [31:0] rd,
                        input logic [11:0] exp);
        @(negedge clk);
        drive(in, rd);
        #2;
        chk(nm, {20'd0, flags()}, {20'd0, exp});
    endtask

    initial begin
        ifu_bus.araddr = 32'h3000_0000; ifu_bus.arid = 4'h1; ifu_bus.arlen = 8'd0;
        ifu_bus.arsize = 3'd2; ifu_bus.arburst = 2'b01;
        ifu_bus.awvalid = 1'b0; ifu_bus.awaddr = '0; ifu_bus.awid = '0; ifu_bus.awlen = '0;
        ifu_bus.awsize = '0; ifu_bus.awburst = '0; ifu_bus.wvalid = 1'b0; ifu_bus.wdata = '0;
        ifu_bus.wstrb = '0; ifu_bus.wlast = 1'b0; ifu_bus.bready = 1'b0;
        lsu_bus.araddr = 32'h8000_0010; lsu_bus.arid = 4'h2; lsu_bus.arlen = 8'd0;
        lsu_bus.arsize = 3'd2; lsu_bus.arburst = 2'b01;
        lsu_bus.awaddr = 32'h0200_4000; lsu_bus.awid = 4'h3; lsu_bus.awlen = 8'd0;
        lsu_bus.awsize = 3'd2; lsu_bus.awburst = 2'b01;
        lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wstrb = 4'hF; lsu_bus.wlast = 1'b1;
        out_bus.rresp = 2'b00; out_bus.rid = 4'h0; out_bus.bresp = 2'b00; out_bus.bid = 4'h0;
        drive(14'b100_000_00_000_000, 32'h0);

        add("rst_hold0",   14'b111_000_00_100_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("rst_hold1",   14'b111_000_00_100_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("rst_hold2",   14'b111_000_00_100_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("idle_arb",    14'b011_000_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("ifu_ar_wait", 14'b011_000_00_000_000, 32'h0,         12'b100_10_00_000_00, 32'h3000_0000);
        add("ifu_ar_hs",   14'b011_000_00_100_000, 32'h0,         12'b100_10_10_000_00, 32'h3000_0000);
        add("ifu_ar_blk",  14'b011_000_00_100_000, 32'h0,         12'b000_10_00_000_00, 32'h0);
        add("ifu_r_last",  14'b011_000_00_100_110, 32'h1111_2222, 12'b000_10_01_000_00, 32'h0);
        add("bubble",      14'b010_000_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("ifu2_ar",     14'b010_000_00_100_000, 32'h0,         12'b100_00_10_000_00, 32'h3000_0000);
        add("ifu2_r_stl",  14'b000_000_00_000_110, 32'h3333_4444, 12'b000_00_01_000_00, 32'h0);
        add("ifu2_r_acc",  14'b001_000_00_000_110, 32'h3333_4444, 12'b000_10_01_000_00, 32'h0);
        add("idle1",       14'b000_000_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("both_rd",     14'b011_000_11_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("lsu_ar_hs",   14'b011_000_11_100_000, 32'h0,         12'b100_10_00_100_00, 32'h8000_0010);
        add("lsu_r_last",  14'b011_000_01_000_110, 32'h5555_6666, 12'b000_10_00_000_10, 32'h0);
        add("ifu_bubble",  14'b011_000_01_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("ifu_ar_hs2",  14'b011_000_01_100_000, 32'h0,         12'b100_10_10_000_00, 32'h3000_0000);
        add("ifu_r_last2", 14'b001_000_01_000_110, 32'h7777_8888, 12'b000_10_01_000_00, 32'h0);
        add("idle2",       14'b000_000_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("w_early0",    14'b000_011_00_001_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("w_early1",    14'b000_011_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("aw_req",      14'b000_111_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("wr_w_hs",     14'b000_111_00_001_000, 32'h0,         12'b011_01_00_001_00, 32'h0);
        add("wr_aw_hs",    14'b000_101_00_010_000, 32'h0,         12'b010_01_00_010_00, 32'h0);
        add("wr_b_hs",     14'b000_001_00_010_001, 32'h0,         12'b000_01_00_000_01, 32'h0);
        add("idle3",       14'b000_000_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("all_req",     14'b010_101_10_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("wr2_aw_hs",   14'b010_101_10_010_000, 32'h0,         12'b010_01_00_010_00, 32'h0);
        add("wr2_w_hs",    14'b010_011_10_001_000, 32'h0,         12'b001_01_00_001_00, 32'h0);
        add("wr2_b_hs",    14'b010_001_10_000_001, 32'h0,         12'b000_01_00_000_01, 32'h0);
        add("rd_after_wr", 14'b010_000_10_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("lsu2_ar_hs",  14'b010_000_10_100_000, 32'h0,         12'b100_00_00_100_00, 32'h8000_0010);
        add("lsu2_r_stl",  14'b010_000_00_000_110, 32'h9999_AAAA, 12'b000_00_00_000_10, 32'h0);
        add("lsu2_r_acc",  14'b010_000_01_000_110, 32'h9999_AAAA, 12'b000_10_00_000_10, 32'h0);
        add("ifu_wait",    14'b010_000_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);
        add("ifu3_ar_hs",  14'b010_000_00_100_000, 32'h0,         12'b100_00_10_000_00, 32'h3000_0000);
        add("ifu3_r_last", 14'b001_000_00_000_110, 32'hBBBB_CCCC, 12'b000_10_01_000_00, 32'h0);
        add("idle4",       14'b000_000_00_000_000, 32'h0,         12'b000_00_00_000_00, 32'h0);

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].in, tbl[k].rdata);
            #2;
            chk(tbl[k].name, {20'd0, flags()}, {20'd0, tbl[k].exp});
            if (tbl[k].exp[11]) chk({tbl[k].name, "_araddr"}, out_bus.araddr, tbl[k].araddr);
            if (tbl[k].exp[5])  chk({tbl[k].name, "_ifu_rdata"}, ifu_bus.rdata, tbl[k].rdata);
            if (tbl[k].exp[1])  chk({tbl[k].name, "_lsu_rdata"}, lsu_bus.rdata, tbl[k].rdata);
            if (out_bus.arvalid && out_bus.arready) n_ar++;
            if (out_bus.awvalid && out_bus.awready) n_aw++;
            if (out_bus.wvalid && out_bus.wready)   n_w++;
            if (out_bus.bvalid && out_bus.bready)   n_b++;
        end
        chk("ar_hs_count", n_ar, 6);
        chk("aw_hs_count", n_aw, 2);
        chk("w_hs_count",  n_w,  2);
        chk("b_hs_count",  n_b,  2);
        chk("ifu_wr_tieoff", {28'd0, ifu_bus.awready, ifu_bus.wready, ifu_bus.bresp}, 32'd0);
        chk("ifu_bvalid_tieoff", {31'd0, ifu_bus.bvalid}, 32'd0);

        // IFU 4-beat burst with toggling rready while an LSU read waits.
        ifu_bus.arlen = 8'd3;
        step("burst_req", 14'b010_000_00_000_000, 32'h0, 12'b000_00_00_000_00);
        step("burst_ar",  14'b010_000_10_100_000, 32'h0, 12'b100_00_10_000_00);
        chk("burst_arlen", {24'd0, out_bus.arlen}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            out_bus.rresp = (i == 3) ? 2'b10 : 2'b00;
            step("burst_stall", {3'b000, 3'b000, 2'b10, 3'b000, 1'b1, (i == 3), 1'b0},
                 32'hB000_0000 + i, 12'b000_00_01_000_00);
            step("burst_beat",  {3'b001, 3'b000, 2'b10, 3'b000, 1'b1, (i == 3), 1'b0},
                 32'hB000_0000 + i, 12'b000_10_01_000_00);
            chk("burst_data", ifu_bus.rdata, 32'hB000_0000 + i);
        end
        chk("burst_err_resp", {30'd0, ifu_bus.rresp}, 32'd2);
        out_bus.rresp = 2'b00;
        step("lsu_still_wait", 14'b000_000_10_000_000, 32'h0, 12'b000_00_00_000_00);
        step("lsu_granted",    14'b000_000_10_100_000, 32'h0, 12'b100_00_00_100_00);
        chk("lsu_granted_addr", out_bus.araddr, 32'h8000_0010);
        step("lsu_r",          14'b000_000_01_000_110, 32'h0000_C0DE, 12'b000_10_00_000_10);
        chk("lsu_r_data", lsu_bus.rdata, 32'h0000_C0DE);
        step("idle5",          14'b000_000_00_000_000, 32'h0, 12'b000_00_00_000_00);

        // Reset lands in the middle of an IFU burst.
        step("mid_req",  14'b010_000_00_000_000, 32'h0, 12'b000_00_00_000_00);
        step("mid_ar",   14'b010_000_00_100_000, 32'h0, 12'b100_00_10_000_00);
        for (int i = 0; i < 2; i++)
            step("mid_beat", 14'b001_000_00_000_100, 32'hD000_0000 + i, 12'b000_10_01_000_00);
        step("mid_rst",      14'b101_000_00_000_100, 32'h0, 12'b000_00_00_000_00);
        step("mid_rst_idle", 14'b000_000_00_000_000, 32'h0, 12'b000_00_00_000_00);
        ifu_bus.araddr = 32'h3000_0040;
        ifu_bus.arlen  = 8'd0;
        step("post_rst_req", 14'b010_000_00_000_000, 32'h0, 12'b000_00_00_000_00);
        step("post_rst_ar",  14'b010_000_00_100_000, 32'h0, 12'b100_00_10_000_00);
        chk("post_rst_addr", out_bus.araddr, 32'h3000_0040);
        chk("post_rst_arlen", {24'd0, out_bus.arlen}, 32'd0);
        step("post_rst_r",   14'b001_000_00_000_110, 32'hE000_0001, 12'b000_10_01_000_00);
        chk("post_rst_data", ifu_bus.rdata, 32'hE000_0001);
        step("idle6",        14'b000_000_00_000_000, 32'h0, 12'b000_00_00_000_00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
